// File: rtl/cnf_loader.sv
// Purpose     : streams a CNF formula in from the host one literal at a time. It builds the per-clause
//               literal rows in data_mem and the per-variable occurrence bitmaps in clause_db, then pulses
//               sat_start.
// Latency     : 3 cycles per literal, plus 1 at each clause end. sat_start comes 4 cycles after the last
//               literal is accepted.
// Backpressure: lit_ready is high only in ACCUM. The host holds lit_valid and its fields until the cycle
//               in which lit_ready is high.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   load_start                   starts a new load; ignored while load_busy
//   lit_valid/lit_ready          literal handshake
//   lit_var/lit_neg/lit_last     literal fields
//   cnf_last                     qualifies lit_last: this clause is the last of the formula
//   dm_en/dm_write/dm_address    data_mem write port, one row per clause
//   dm_in                        clause row; bits[2v+1:2v] = {neg,pos} for variable v
//   cdb_en/cdb_write/cdb_address clause_db port, one row per variable
//   cdb_in                       occurrence bitmap being written
//   cdb_out                      clause_db read data, valid one cycle after the read
//   clause_count                 clauses stored by the last or current load
//   load_busy/load_err/sat_start load status
module cnf_loader #(
    parameter int VAR_NUM    = 8,
    parameter int VAR_LOG    = 3,
    parameter int CLAUSE_NUM = 16,
    parameter int CLAUSE_LOG = 4,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  lit_valid,
    output logic                  lit_ready,
    input  logic [VAR_LOG-1:0]    lit_var,
    input  logic                  lit_neg,
    input  logic                  lit_last,
    input  logic                  cnf_last,
    output logic                  dm_en,
    output logic                  dm_write,
    output logic [CLAUSE_LOG-1:0] dm_address,
    output logic [DATA_W-1:0]     dm_in,
    output logic                  cdb_en,
    output logic                  cdb_write,
    output logic [VAR_LOG-1:0]    cdb_address,
    output logic [CLAUSE_NUM-1:0] cdb_in,
    input  logic [CLAUSE_NUM-1:0] cdb_out,
    output logic [CLAUSE_LOG:0]   clause_count,
    output logic                  load_busy,
    output logic                  load_err,
    output logic                  sat_start
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_CDB_RD,
        S_CDB_WR,
        S_DM_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [VAR_LOG-1:0]  clear_ptr;
    logic [DATA_W-1:0]   row_q;
    // One bit wider than a row address, so the index can hold CLAUSE_NUM when data_mem is full.
    logic [CLAUSE_LOG:0] clause_idx;
    logic [VAR_LOG-1:0]  lat_var;
    logic                lat_last;
    logic                lat_cnf_last;

    logic        accept;
    logic        var_bad;
    logic        db_full;
    logic [1:0]  lit_pair;
    logic        conflict;
    logic        lit_err;

    assign accept   = (state == S_ACCUM) && lit_valid;
    assign var_bad  = {1'b0, lit_var} >= (VAR_LOG+1)'(VAR_NUM);
    assign db_full  = clause_idx == (CLAUSE_LOG+1)'(CLAUSE_NUM);
    // The {neg,pos} pair already in this clause for the incoming variable.
    assign lit_pair = row_q[{lit_var, 1'b0} +: 2];
    // A conflict is a literal whose opposite polarity is already in the clause.
    // A repeat of the same polarity is harmless.
    assign conflict = lit_neg ? lit_pair[0] : lit_pair[1];
    assign lit_err  = var_bad || db_full || conflict;

    assign clause_count = clause_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load_start) state_nxt = S_CLEAR;
            S_CLEAR:  if (clear_ptr == VAR_LOG'(VAR_NUM - 1)) state_nxt = S_ACCUM;
            S_ACCUM:  if (accept) state_nxt = lit_err ? S_ERR : S_CDB_RD;
            S_CDB_RD: state_nxt = S_CDB_WR;
            S_CDB_WR: state_nxt = lat_last ? S_DM_WR : S_ACCUM;
            S_DM_WR:  state_nxt = lat_cnf_last ? S_DONE : S_ACCUM;
            S_DONE:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode. Every memory port signal is 0 unless the state drives it.
    always_comb begin
        lit_ready   = 1'b0;
        dm_en       = 1'b0;
        dm_write    = 1'b0;
        dm_address  = '0;
        dm_in       = '0;
        cdb_en      = 1'b0;
        cdb_write   = 1'b0;
        cdb_address = '0;
        cdb_in      = '0;
        sat_start   = 1'b0;
        case (state)
            S_CLEAR: begin
                cdb_en      = 1'b1;
                cdb_write   = 1'b1;
                cdb_address = clear_ptr;
            end
            S_ACCUM: begin
                lit_ready = 1'b1;
            end
            S_CDB_RD: begin
                cdb_en      = 1'b1;
                cdb_address = lat_var;
            end
            S_CDB_WR: begin
                cdb_en      = 1'b1;
                cdb_write   = 1'b1;
                cdb_address = lat_var;
                cdb_in      = cdb_out | (CLAUSE_NUM'(1) << clause_idx[CLAUSE_LOG-1:0]);
            end
            S_DM_WR: begin
                dm_en      = 1'b1;
                dm_write   = 1'b1;
                dm_address = clause_idx[CLAUSE_LOG-1:0];
                dm_in      = row_q;
            end
            S_DONE: begin
                sat_start = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clear_ptr    <= '0;
            row_q        <= '0;
            clause_idx   <= '0;
            lat_var      <= '0;
            lat_last     <= 1'b0;
            lat_cnf_last <= 1'b0;
            load_busy    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        load_err   <= 1'b0;
                        load_busy  <= 1'b1;
                        clear_ptr  <= '0;
                        clause_idx <= '0;
                        // An aborted previous load may have left a partial row behind.
                        row_q      <= '0;
                    end
                end
                S_CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                end
                S_ACCUM: begin
                    if (accept && !lit_err) begin
                        lat_var      <= lit_var;
                        lat_last     <= lit_last;
                        lat_cnf_last <= cnf_last;
                        row_q        <= row_q | (DATA_W'(1) << {lit_var, lit_neg});
                    end
                end
                S_DM_WR: begin
                    row_q      <= '0;
                    clause_idx <= clause_idx + 1'b1;
                end
                S_DONE: begin
                    load_busy <= 1'b0;
                end
                S_ERR: begin
                    load_err  <= 1'b1;
                    load_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
